// File: rtl/shift_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : shift_word_tx
//  Purpose  : Parallel-to-serial word transmitter. Accepts WIDTH-bit words on
//             a valid/ready handshake and emits them one bit per clock on
//             shift_out. A one-entry holding register lets consecutive words
//             stream back to back with no idle cycles on the serial side.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous, active-low reset
//             din        - parallel word to transmit
//             din_valid  - din holds a word
//             din_ready  - block can accept a word this cycle
//             shift_out  - current serial bit (0 when shift_en=0)
//             shift_en   - shift_out carries a valid bit this cycle
//             shift_sof  - high on the first bit of every word
//             busy       - shifter or holding register occupied
//  Revision : 1.0 - initial release
// ============================================================================
module shift_word_tx #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             shift_out,
    output logic             shift_en,
    output logic             shift_sof,
    output logic             busy
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [c_cnt_w-1:0] bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic [WIDTH-1:0]   hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;

    logic               w_accept;
    logic               w_last_bit;
    logic               w_slot_free;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_out_bit;

    // Bit ordering only affects which end of the shifter faces the output
    // and which way the word moves toward it.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit = shreg_q[WIDTH-1];
            assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = shreg_q[0];
            assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign din_ready   = !hold_full_q;
    assign w_accept    = din_valid && din_ready;
    assign w_last_bit  = (state_q == SHIFT) && (bit_cnt_q == c_last);
    // The shifter can take a new word at this edge when it is empty or when
    // its final bit is being presented right now.
    assign w_slot_free = (state_q == IDLE) || w_last_bit;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (hold_full_q && w_slot_free) begin
            // Held word has priority: it was accepted before anything on din.
            shreg_d     = hold_q;
            bit_cnt_d   = '0;
            state_d     = SHIFT;
            hold_full_d = 1'b0;
        end else if (w_accept && w_slot_free) begin
            shreg_d   = din;
            bit_cnt_d = '0;
            state_d   = SHIFT;
        end else if (w_last_bit) begin
            state_d = IDLE;
        end else if (state_q == SHIFT) begin
            shreg_d   = w_shifted;
            bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
        end

        // Parking a word in the holding register runs alongside the shift
        // of the current word so the serial stream is not interrupted.
        if (w_accept && (state_q == SHIFT) && !w_last_bit) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign shift_en  = (state_q == SHIFT);
    assign shift_out = shift_en && w_out_bit;
    assign shift_sof = shift_en && (bit_cnt_q == '0);
    assign busy      = shift_en || hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_word_tx
//  Purpose  : Self-checking bench for shift_word_tx. Two instances (MSB-first
//             and LSB-first) share stimulus; each accepted word is expanded
//             into its expected bit sequence and queued, and a monitor pops
//             and compares every serial bit, strobe and handshake output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_word_tx;

    localparam int WIDTH = 8;

    typedef logic [1:0] ent_t;   // {sof, bit}

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;

    logic [1:0] rdy_w, so_w, en_w, sof_w, busy_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int d, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %b expected %b", nm, d, $time, act, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            localparam bit MSB = (g == 0);
            ent_t q[$];

            shift_word_tx #(.WIDTH(WIDTH), .MSB_FIRST(MSB)) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .din       (din),
                .din_valid (din_valid),
                .din_ready (rdy_w[g]),
                .shift_out (so_w[g]),
                .shift_en  (en_w[g]),
                .shift_sof (sof_w[g]),
                .busy      (busy_w[g])
            );

            // Reference: an accepted word becomes WIDTH queued bits in
            // transmission order, the first one tagged as start of frame.
            always @(posedge clk) begin
                if (rst_n && din_valid && rdy_w[g]) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        int idx;
                        idx = MSB ? (WIDTH - 1 - i) : i;
                        q.push_back({(i == 0), din[idx]});
                    end
                end
            end

            // Monitor: outstanding bits in the model define every output.
            // More than one word outstanding means the holding register is
            // occupied, so the block must refuse input.
            always @(negedge clk) begin
                if (!rst_n) begin
                    q.delete();
                end else begin
                    int sz;
                    sz = q.size();
                    check("shift_en",  g, en_w[g],   sz != 0);
                    check("busy",      g, busy_w[g], sz != 0);
                    check("din_ready", g, rdy_w[g],  sz <= WIDTH);
                    if (sz != 0) begin
                        ent_t e;
                        e = q[0];
                        check("shift_out", g, so_w[g],  e[0]);
                        check("shift_sof", g, sof_w[g], e[1]);
                        if (en_w[g]) void'(q.pop_front());
                    end else begin
                        check("idle_shift_out", g, so_w[g],  1'b0);
                        check("idle_shift_sof", g, sof_w[g], 1'b0);
                    end
                end
            end
        end
    endgenerate

    // 16-stage serial delay chain fed by the MSB-first transmitter.
    logic [15:0] chain = '0;
    logic        hist[$];

    always @(posedge clk) chain <= {chain[14:0], so_w[0]};

    always @(negedge clk) begin
        if (!rst_n) begin
            hist.delete();
        end else begin
            hist.push_back(so_w[0]);
            if (hist.size() >= 17) begin
                check("loopback", 0, chain[15], hist[hist.size() - 17]);
                void'(hist.pop_front());
            end
        end
    end

    // Offer one word; hold din_valid until accepted. While the block refuses
    // input, din carries junk that must never be captured.
    task automatic send_word(input logic [WIDTH-1:0] w);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        din_valid = 1'b1;
        while (!done) begin
            if (rdy_w[0]) din = w;
            else          din = WIDTH'($urandom);
            done = rdy_w[0];
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout word %h: not accepted in %0d cycles", w, n);
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        din_valid = 1'b0;
        din = WIDTH'($urandom);
        while ((g_dut[0].q.size() != 0 || g_dut[1].q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d bits still pending", g_dut[0].q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            check("rst_shift_en",  d, en_w[d],   1'b0);
            check("rst_shift_out", d, so_w[d],   1'b0);
            check("rst_shift_sof", d, sof_w[d],  1'b0);
            check("rst_busy",      d, busy_w[d], 1'b0);
            check("rst_din_ready", d, rdy_w[d],  1'b1);
        end
    endtask

    initial begin
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single words, including the palindrome and a lone set bit.
        send_word(8'hA5);
        drain();
        send_word(8'h01);
        drain();

        // Back-to-back streaming with din_valid held high.
        send_word(8'h0F);
        send_word(8'hF0);
        drain();

        // Backpressure: three words offered continuously.
        send_word(8'hAA);
        send_word(8'h55);
        send_word(8'hC3);
        drain();

        // Randomised traffic: mixed gaps and gapless bursts.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                din_valid = 1'b0;
                repeat ($urandom_range(0, WIDTH + 2)) begin
                    din = WIDTH'($urandom);
                    @(posedge clk); #1;
                end
            end
            send_word(WIDTH'($urandom));
        end
        drain();

        // Reset in the middle of a word with another word parked.
        send_word(8'h96);
        send_word(8'h3C);
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame after reset, then more random traffic.
        send_word(8'hE7);
        for (int k = 0; k < 20; k++) send_word(WIDTH'($urandom));
        drain();
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
